// File: rtl/fifo_pkg.sv
// Shared types and helpers for the variable-burst FIFO.
package fifo_pkg;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef struct packed {
    logic push_ack;
    logic pop_ack;
    logic push_err;
    logic pop_err;
  } fifo_status_t;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modular pointer advance: wrapped = (ptr + inc) mod DEPTH, valid for inc <= DEPTH.
module fifo_ptr_wrap #(
  parameter int DEPTH = 16,
  parameter int PtrW  = 4,
  parameter int NW    = 3
) (
  input  logic [PtrW-1:0] ptr,
  input  logic [NW-1:0]   inc,
  output logic [PtrW-1:0] wrapped
);

  logic [31:0] sum;

  always_comb begin
    sum = 32'(ptr) + 32'(inc);
    if (sum >= 32'(DEPTH)) sum = sum - 32'(DEPTH);
    wrapped = sum[PtrW-1:0];
  end

endmodule

// File: rtl/var_burst_fifo.sv
// Multi-element push/pop FIFO with all-or-nothing bursts and zero-latency head view.
// Sticky err_o and its assertions exist only when VAR_BURST_FIFO_ERR_EN is defined.
module var_burst_fifo
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 16,
  parameter int  N_IN       = 4,
  parameter int  N_OUT      = 2,
  parameter type dtype      = logic [DATA_WIDTH-1:0],
  localparam int CntW       = cnt_width(DEPTH),
  localparam int InW        = cnt_width(N_IN),
  localparam int OutW       = cnt_width(N_OUT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [InW-1:0]   push_cnt_i,
  input  dtype             data_i [N_IN],
  output logic             push_ack_o,
  input  logic             pop_i,
  input  logic [OutW-1:0]  pop_cnt_i,
  output logic             pop_ack_o,
  output dtype             data_o [N_OUT],
  output logic [N_OUT-1:0] valid_o,
  output logic [CntW-1:0]  used_o,
  output logic [CntW-1:0]  free_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             err_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, rd_ptr_nxt, wr_ptr_nxt;
  logic [CntW-1:0] used_q;
  logic [CntW:0]   used_nxt;
  dtype            mem_q [DEPTH];
  fifo_status_t    status;

  function automatic logic [PtrW-1:0] slot(input logic [PtrW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PtrW-1:0];
  endfunction

  assign used_o  = used_q;
  assign free_o  = CntW'(DEPTH) - used_q;
  assign full_o  = int'(free_o) < N_IN;
  assign empty_o = (used_q == '0);

  // Acceptance looks only at registered occupancy, so a same-cycle pop never frees room.
  always_comb begin
    status = '0;
    if (rst_ni && !flush_i) begin
      if (push_i && push_cnt_i != '0) begin
        if (int'(push_cnt_i) <= int'(free_o) && int'(push_cnt_i) <= N_IN) status.push_ack = 1'b1;
        else status.push_err = 1'b1;
      end
      if (pop_i && pop_cnt_i != '0) begin
        if (int'(pop_cnt_i) <= int'(used_q) && int'(pop_cnt_i) <= N_OUT) status.pop_ack = 1'b1;
        else if (int'(pop_cnt_i) > int'(used_q)) status.pop_err = 1'b1;
      end
    end
  end

  assign push_ack_o = status.push_ack;
  assign pop_ack_o  = status.pop_ack;

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PtrW(PtrW), .NW(InW)) u_wr_wrap (
    .ptr     (wr_ptr_q),
    .inc     (push_cnt_i),
    .wrapped (wr_ptr_nxt)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PtrW(PtrW), .NW(OutW)) u_rd_wrap (
    .ptr     (rd_ptr_q),
    .inc     (pop_cnt_i),
    .wrapped (rd_ptr_nxt)
  );

  always_comb begin
    used_nxt = {1'b0, used_q}
             + (status.push_ack ? (CntW+1)'(push_cnt_i) : '0)
             - (status.pop_ack  ? (CntW+1)'(pop_cnt_i)  : '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (status.push_ack) wr_ptr_q <= wr_ptr_nxt;
      if (status.pop_ack)  rd_ptr_q <= rd_ptr_nxt;
      used_q <= used_nxt[CntW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (status.push_ack) begin
      for (int k = 0; k < N_IN; k++) begin
        if (k < int'(push_cnt_i)) mem_q[slot(wr_ptr_q, k)] <= data_i[k];
      end
    end
  end

  always_comb begin
    valid_o = '0;
    for (int k = 0; k < N_OUT; k++) begin
      data_o[k]  = mem_q[slot(rd_ptr_q, k)];
      valid_o[k] = k < int'(used_q);
    end
  end

`ifdef VAR_BURST_FIFO_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                err_q <= 1'b0;
    else if (flush_i)                           err_q <= 1'b0;
    else if (status.push_err || status.pop_err) err_q <= 1'b1;
  end

  assign err_o = err_q;

  a_reject_flags_err: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (status.push_err || status.pop_err) |=> err_q);

  a_legal_params: assert property (@(posedge clk_i)
    DEPTH >= 2 && DEPTH <= 256 && N_IN >= 1 && N_IN <= DEPTH && N_OUT >= 1 && N_OUT <= DEPTH);
`else
  logic unused_err;
  assign unused_err = status.push_err | status.pop_err;
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_var_burst_fifo.sv
// Directed bench for var_burst_fifo (DEPTH=8, N_IN=4, N_OUT=2); expectations are hand-computed.
module tb_var_burst_fifo;

  localparam int DW = 32;
`ifdef VAR_BURST_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, push_i, pop_i;
  logic [2:0]    push_cnt_i;
  logic [1:0]    pop_cnt_i;
  logic [DW-1:0] data_i [4];
  logic [DW-1:0] data_o [2];
  logic          push_ack_o, pop_ack_o, full_o, empty_o, err_o;
  logic [1:0]    valid_o;
  logic [3:0]    used_o, free_o;

  int n_cmp = 0;
  int n_bad = 0;

  var_burst_fifo #(.DATA_WIDTH(DW), .DEPTH(8), .N_IN(4), .N_OUT(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .push_i(push_i), .push_cnt_i(push_cnt_i), .data_i(data_i), .push_ack_o(push_ack_o),
    .pop_i(pop_i), .pop_cnt_i(pop_cnt_i), .pop_ack_o(pop_ack_o),
    .data_o(data_o), .valid_o(valid_o), .used_o(used_o), .free_o(free_o),
    .full_o(full_o), .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; push_i = 0; pop_i = 0; push_cnt_i = 0; pop_cnt_i = 0;
  endtask

  task automatic drive_push(input int cnt, input logic [DW-1:0] d0, d1, d2, d3);
    push_i = 1; push_cnt_i = 3'(cnt);
    data_i[0] = d0; data_i[1] = d1; data_i[2] = d2; data_i[3] = d3;
  endtask

  task automatic test_reset();
    rst_ni = 0; idle();
    for (int i = 0; i < 4; i++) data_i[i] = '0;
    #12;
    n_cmp++; if (used_o !== 4'd0) begin n_bad++; $display("FAIL rst_used got=%0d exp=0", used_o); end
    n_cmp++; if (free_o !== 4'd8) begin n_bad++; $display("FAIL rst_free got=%0d exp=8", free_o); end
    n_cmp++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin n_bad++; $display("FAIL rst_flags empty=%b full=%b exp 1/0", empty_o, full_o); end
    n_cmp++; if (valid_o !== 2'b00) begin n_bad++; $display("FAIL rst_valid got=%b exp=00", valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    n_cmp++; if (data_o[0] !== 32'h0) begin n_bad++; $display("FAIL rst_mem got=%h exp=0", data_o[0]); end
    rst_ni = 1;
  endtask

  task automatic test_push_basic();
    drive_push(3, 32'hA, 32'hB, 32'hC, 32'hFF);
    #1;
    n_cmp++; if (push_ack_o !== 1'b1) begin n_bad++; $display("FAIL push3_ack got=%b exp=1", push_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd3) begin n_bad++; $display("FAIL push3_used got=%0d exp=3", used_o); end
    n_cmp++; if (data_o[0] !== 32'hA || data_o[1] !== 32'hB) begin n_bad++; $display("FAIL push3_data got=%h,%h exp=a,b", data_o[0], data_o[1]); end
    n_cmp++; if (valid_o !== 2'b11) begin n_bad++; $display("FAIL push3_valid got=%b exp=11", valid_o); end
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL push3_err got=%b exp=0", err_o); end
  endtask

  task automatic test_overflow();
    drive_push(3, 32'hD, 32'hE, 32'hF, 32'hFF);
    step(); idle();
    n_cmp++; if (used_o !== 4'd6 || full_o !== 1'b1) begin n_bad++; $display("FAIL ovf_pre used=%0d full=%b exp 6/1", used_o, full_o); end
    drive_push(3, 32'h11, 32'h12, 32'h13, 32'hFF);
    #1;
    n_cmp++; if (push_ack_o !== 1'b0) begin n_bad++; $display("FAIL ovf_ack got=%b exp=0", push_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd6) begin n_bad++; $display("FAIL ovf_used got=%0d exp=6", used_o); end
    n_cmp++; if (err_o !== ERR) begin n_bad++; $display("FAIL ovf_err got=%b exp=%b", err_o, ERR); end
  endtask

  task automatic test_pop();
    pop_i = 1; pop_cnt_i = 2;
    #1;
    n_cmp++; if (pop_ack_o !== 1'b1) begin n_bad++; $display("FAIL pop_ack got=%b exp=1", pop_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd4 || data_o[0] !== 32'hC || data_o[1] !== 32'hD) begin
      n_bad++; $display("FAIL pop_state used=%0d data=%h,%h exp 4 c,d", used_o, data_o[0], data_o[1]); end
  endtask

  task automatic test_simul_wrap();
    drive_push(4, 32'h6, 32'h7, 32'h8, 32'h9);
    pop_i = 1; pop_cnt_i = 2;
    #1;
    n_cmp++; if (push_ack_o !== 1'b1 || pop_ack_o !== 1'b1) begin n_bad++; $display("FAIL simul_acks push=%b pop=%b exp 1/1", push_ack_o, pop_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd6) begin n_bad++; $display("FAIL simul_used got=%0d exp=6", used_o); end
    n_cmp++; if (data_o[0] !== 32'hE || data_o[1] !== 32'hF) begin n_bad++; $display("FAIL simul_head got=%h,%h exp=e,f", data_o[0], data_o[1]); end
    pop_i = 1; pop_cnt_i = 2; step();
    n_cmp++; if (data_o[0] !== 32'h6 || data_o[1] !== 32'h7) begin n_bad++; $display("FAIL wrap_0 got=%h,%h exp=6,7", data_o[0], data_o[1]); end
    step();
    n_cmp++; if (data_o[0] !== 32'h8 || data_o[1] !== 32'h9) begin n_bad++; $display("FAIL wrap_1 got=%h,%h exp=8,9", data_o[0], data_o[1]); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd0 || empty_o !== 1'b1) begin n_bad++; $display("FAIL drain used=%0d empty=%b exp 0/1", used_o, empty_o); end
  endtask

  task automatic test_underflow();
    drive_push(1, 32'h4B, 32'hFF, 32'hFF, 32'hFF);
    step(); idle();
    pop_i = 1; pop_cnt_i = 2;
    #1;
    n_cmp++; if (pop_ack_o !== 1'b0) begin n_bad++; $display("FAIL unf_ack got=%b exp=0", pop_ack_o); end
    n_cmp++; if (valid_o !== 2'b01 || data_o[0] !== 32'h4B) begin n_bad++; $display("FAIL unf_view valid=%b d0=%h exp 01 4b", valid_o, data_o[0]); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd1) begin n_bad++; $display("FAIL unf_used got=%0d exp=1", used_o); end
    n_cmp++; if (err_o !== ERR) begin n_bad++; $display("FAIL unf_err got=%b exp=%b", err_o, ERR); end
  endtask

  task automatic test_zero_cnt();
    push_i = 1; push_cnt_i = 0; pop_i = 1; pop_cnt_i = 0;
    #1;
    n_cmp++; if (push_ack_o !== 1'b0 || pop_ack_o !== 1'b0) begin n_bad++; $display("FAIL zero_acks push=%b pop=%b exp 0/0", push_ack_o, pop_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd1) begin n_bad++; $display("FAIL zero_used got=%0d exp=1", used_o); end
  endtask

  task automatic test_flush();
    drive_push(2, 32'h21, 32'h22, 32'hFF, 32'hFF);
    pop_i = 1; pop_cnt_i = 1; flush_i = 1;
    #1;
    n_cmp++; if (push_ack_o !== 1'b0 || pop_ack_o !== 1'b0) begin n_bad++; $display("FAIL flush_acks push=%b pop=%b exp 0/0", push_ack_o, pop_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd0 || empty_o !== 1'b1 || err_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_state used=%0d empty=%b err=%b exp 0/1/0", used_o, empty_o, err_o); end
    n_cmp++; if (data_o[0] !== 32'h8 || data_o[1] !== 32'h9) begin n_bad++; $display("FAIL flush_mem got=%h,%h exp=8,9", data_o[0], data_o[1]); end
  endtask

  task automatic test_reset_mid_burst();
    drive_push(2, 32'h31, 32'h32, 32'hFF, 32'hFF);
    #2 rst_ni = 0;
    #1;
    n_cmp++; if (push_ack_o !== 1'b0 || data_o[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid_now ack=%b d0=%h exp 0/0", push_ack_o, data_o[0]); end
    step(); idle(); rst_ni = 1;
    #1;
    n_cmp++; if (used_o !== 4'd0 || data_o[0] !== 32'h0) begin n_bad++; $display("FAIL rstmid_after used=%0d d0=%h exp 0/0", used_o, data_o[0]); end
  endtask

  task automatic test_full_boundary();
    drive_push(4, 32'h40, 32'h41, 32'h42, 32'h43); step();
    drive_push(4, 32'h44, 32'h45, 32'h46, 32'h47); step(); idle();
    n_cmp++; if (used_o !== 4'd8 || free_o !== 4'd0 || full_o !== 1'b1) begin
      n_bad++; $display("FAIL full_state used=%0d free=%0d full=%b exp 8/0/1", used_o, free_o, full_o); end
    drive_push(1, 32'h50, 32'hFF, 32'hFF, 32'hFF);
    pop_i = 1; pop_cnt_i = 2;
    #1;
    n_cmp++; if (push_ack_o !== 1'b0 || pop_ack_o !== 1'b1) begin n_bad++; $display("FAIL full_acks push=%b pop=%b exp 0/1", push_ack_o, pop_ack_o); end
    step(); idle();
    n_cmp++; if (used_o !== 4'd6 || data_o[0] !== 32'h42 || data_o[1] !== 32'h43) begin
      n_bad++; $display("FAIL full_after used=%0d data=%h,%h exp 6 42,43", used_o, data_o[0], data_o[1]); end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_overflow();
    test_pop();
    test_simul_wrap();
    test_underflow();
    test_zero_cnt();
    test_flush();
    test_reset_mid_burst();
    test_full_boundary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
